// File: rtl/iram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iram_pkg
//  Description : Shared encodings for the internal-RAM access sequencer:
//                execute-unit operation codes, FSM state encoding, reset and
//                region constants, and small decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package iram_pkg;

    // Execute-unit operation codes
    typedef enum logic [2:0] {
        OP_RD   = 3'd0,
        OP_WR   = 3'd1,
        OP_IRD  = 3'd2,
        OP_IWR  = 3'd3,
        OP_PUSH = 3'd4,
        OP_POP  = 3'd5,
        OP_BRD  = 3'd6,
        OP_BWR  = 3'd7
    } op_e;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PTR     = 3'd1;
    localparam logic [2:0] ST_PTR_CAP = 3'd2;
    localparam logic [2:0] ST_ACCESS  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [7:0] SP_RESET_DEFAULT  = 8'h07;
    localparam logic [7:0] ERR_RDATA_DEFAULT = 8'hFF;
    localparam logic [7:0] SFR_BASE          = 8'h80;

    // Upper half of the address space belongs to the SFR block
    function automatic logic is_sfr(input logic [7:0] a);
        return (a >= SFR_BASE);
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        return (op == OP_WR) || (op == OP_IWR) || (op == OP_PUSH) || (op == OP_BWR);
    endfunction

    function automatic logic op_is_bit(input logic [2:0] op);
        return (op == OP_BRD) || (op == OP_BWR);
    endfunction

    function automatic logic op_is_indirect(input logic [2:0] op);
        return (op == OP_IRD) || (op == OP_IWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iram_access_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : iram_access_seq_if
//  Description : Execute-unit request/response bundle for the internal-RAM
//                sequencer (request, SP load, completion and read results).
//  Revision    : 1.0  initial release
// ============================================================================
interface iram_access_seq_if;
    logic       req;
    logic [2:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] rs;
    logic       sp_wr;
    logic [7:0] sp_wdata;
    logic       busy;
    logic       ack;
    logic       err;
    logic [7:0] rdata;
    logic       rbit;
    logic [7:0] sp;

    // Execute unit side
    modport master (
        output req, op, addr, wdata, rs, sp_wr, sp_wdata,
        input  busy, ack, err, rdata, rbit, sp
    );

    // Sequencer side
    modport slave (
        input  req, op, addr, wdata, rs, sp_wr, sp_wdata,
        output busy, ack, err, rdata, rbit, sp
    );
endinterface
`default_nettype wire

// File: rtl/iram_stack_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : iram_stack_ptr
//  Description : 8051 stack pointer register. Load has priority over
//                increment, increment over decrement; arithmetic wraps mod 256.
//  Revision    : 1.0  initial release
// ============================================================================
module iram_stack_ptr #(
    parameter logic [7:0] SP_RESET = 8'h07
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_load_val,
    input  wire logic       i_inc,
    input  wire logic       i_dec,
    output logic [7:0]      o_sp
);

    logic [7:0] r_sp;

    // SP update: load / increment / decrement / hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp <= SP_RESET;
        end else if (i_load) begin
            r_sp <= i_load_val;
        end else if (i_inc) begin
            r_sp <= r_sp + 8'd1;
        end else if (i_dec) begin
            r_sp <= r_sp - 8'd1;
        end
    end

    assign o_sp = r_sp;

endmodule
`default_nettype wire

// File: rtl/iram_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : iram_access_seq
//  Description : Sequencer between the 8051 execute unit and the 256-byte
//                internal RAM. Expands one request into pointer-fetch, access
//                and capture cycles, enforces the SFR region split and owns SP.
//                All RAM-port and response outputs come straight from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module iram_access_seq
    import iram_pkg::*;
#(
    parameter logic [7:0] SP_RESET  = SP_RESET_DEFAULT,
    parameter logic [7:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    iram_access_seq_if.slave exu,
    output logic             ram_rd,
    output logic             ram_wr,
    output logic             ram_is_bit,
    output logic             ram_bit_wdata,
    output logic [7:0]       ram_wdata,
    output logic [7:0]       ram_addr,
    input  wire logic [7:0]  ram_rdata,
    input  wire logic        ram_bit_rdata
);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [2:0] r_op;
    logic [2:0] w_op;
    logic [7:0] r_wdata;
    logic [7:0] w_wdata;
    logic [7:0] w_tgt;
    logic       w_err_nxt;
    logic       w_accept;
    logic       w_sp_load;
    logic       w_sp_inc;
    logic       w_sp_dec;
    logic [7:0] w_sp;

    logic       r_busy;
    logic       r_ack;
    logic       r_err;
    logic       r_rbit;
    logic [7:0] r_rdata;

    logic       r_ram_rd;
    logic       r_ram_wr;
    logic       r_ram_is_bit;
    logic       r_ram_bit_wdata;
    logic [7:0] r_ram_wdata;
    logic [7:0] r_ram_addr;

    // An SP load in IDLE takes the cycle; a simultaneous request waits one cycle
    assign w_accept  = (r_state == ST_IDLE) && exu.req && !exu.sp_wr;
    assign w_sp_load = (r_state == ST_IDLE) && exu.sp_wr;
    assign w_sp_inc  = w_accept && (exu.op == OP_PUSH);
    assign w_sp_dec  = (r_state == ST_CAPTURE) && (r_op == OP_POP);

    // In IDLE the live request fields are used; afterwards the captured copies
    assign w_op    = (r_state == ST_IDLE) ? exu.op    : r_op;
    assign w_wdata = (r_state == ST_IDLE) ? exu.wdata : r_wdata;

    iram_stack_ptr #(
        .SP_RESET (SP_RESET)
    ) u_stack_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_sp_load),
        .i_load_val (exu.sp_wdata),
        .i_inc      (w_sp_inc),
        .i_dec      (w_sp_dec),
        .o_sp       (w_sp)
    );

    // Next state, access target and region check
    always_comb begin
        w_state_nxt = r_state;
        w_tgt       = 8'h00;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (exu.op)
                        OP_IRD, OP_IWR: w_state_nxt = ST_PTR;
                        OP_PUSH:        w_tgt = w_sp + 8'd1;
                        OP_POP:         w_tgt = w_sp;
                        default:        w_tgt = exu.addr;
                    endcase
                    if (!op_is_indirect(exu.op)) begin
                        w_err_nxt   = is_sfr(w_tgt);
                        w_state_nxt = w_err_nxt ? ST_DONE : ST_ACCESS;
                    end
                end
            end
            ST_PTR: begin
                w_state_nxt = ST_PTR_CAP;
            end
            ST_PTR_CAP: begin
                w_tgt       = ram_rdata;
                w_err_nxt   = is_sfr(ram_rdata);
                w_state_nxt = w_err_nxt ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                w_state_nxt = op_is_write(r_op) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, request capture and handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_RD;
            r_wdata <= 8'h00;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ack   <= (w_state_nxt == ST_DONE);
            r_err   <= (w_state_nxt == ST_DONE) && w_err_nxt;
            if (w_accept) begin
                r_op    <= exu.op;
                r_wdata <= exu.wdata;
            end
        end
    end

    // Read results: refused reads report the error pattern, others capture RAM data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 8'h00;
            r_rbit  <= 1'b0;
        end else if ((w_state_nxt == ST_DONE) && w_err_nxt && !op_is_write(w_op)) begin
            r_rdata <= ERR_RDATA;
            r_rbit  <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            if (r_op == OP_BRD) begin
                r_rbit <= ram_bit_rdata;
            end else begin
                r_rdata <= ram_rdata;
            end
        end
    end

    // RAM port: idle encoding unless the next cycle is a pointer fetch or access.
    // ram_rd drops only for a write access because the RAM writes whenever rd=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_rd        <= 1'b1;
            r_ram_wr        <= 1'b0;
            r_ram_is_bit    <= 1'b0;
            r_ram_bit_wdata <= 1'b0;
            r_ram_wdata     <= 8'h00;
            r_ram_addr      <= 8'h00;
        end else begin
            r_ram_rd        <= 1'b1;
            r_ram_wr        <= 1'b0;
            r_ram_is_bit    <= 1'b0;
            r_ram_bit_wdata <= 1'b0;
            r_ram_wdata     <= 8'h00;
            r_ram_addr      <= 8'h00;
            if (w_state_nxt == ST_PTR) begin
                r_ram_addr <= {3'b000, exu.rs, 2'b00, exu.addr[0]};
            end else if (w_state_nxt == ST_ACCESS) begin
                r_ram_addr   <= w_tgt;
                r_ram_is_bit <= op_is_bit(w_op);
                if (op_is_write(w_op)) begin
                    r_ram_rd        <= 1'b0;
                    r_ram_wr        <= 1'b1;
                    r_ram_wdata     <= w_wdata;
                    r_ram_bit_wdata <= w_wdata[0];
                end
            end
        end
    end

    assign exu.busy      = r_busy;
    assign exu.ack       = r_ack;
    assign exu.err       = r_err;
    assign exu.rdata     = r_rdata;
    assign exu.rbit      = r_rbit;
    assign exu.sp        = w_sp;

    assign ram_rd        = r_ram_rd;
    assign ram_wr        = r_ram_wr;
    assign ram_is_bit    = r_ram_is_bit;
    assign ram_bit_wdata = r_ram_bit_wdata;
    assign ram_wdata     = r_ram_wdata;
    assign ram_addr      = r_ram_addr;

endmodule
`default_nettype wire

// File: tb/tb_iram_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iram_access_seq
//  Description : Self-checking bench for iram_access_seq with a registered
//                RAM model and an operation-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iram_access_seq;
    import iram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iram_access_seq_if exu ();
    logic       ram_rd, ram_wr, ram_is_bit, ram_bit_wdata;
    logic [7:0] ram_wdata, ram_addr, ram_rdata;
    logic       ram_bit_rdata;

    iram_access_seq dut (
        .clk           (clk),
        .rst           (rst),
        .exu           (exu),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_is_bit    (ram_is_bit),
        .ram_bit_wdata (ram_bit_wdata),
        .ram_wdata     (ram_wdata),
        .ram_addr      (ram_addr),
        .ram_rdata     (ram_rdata),
        .ram_bit_rdata (ram_bit_rdata)
    );

    // Behavioural RAM: registered read, byte write whenever rd=0 in byte mode
    logic [7:0] ram_mem [256];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'($urandom);
            mem_ready <= 1'b1;
        end else begin
            if (!ram_is_bit && !ram_rd) ram_mem[ram_addr] <= ram_wdata;
            if (ram_is_bit && ram_wr && !ram_addr[7])
                ram_mem[{4'h2, ram_addr[6:3]}][ram_addr[2:0]] <= ram_bit_wdata;
        end
        ram_rdata     <= ram_mem[ram_addr];
        ram_bit_rdata <= ram_mem[{4'h2, ram_addr[6:3]}][ram_addr[2:0]];
    end

    // Port monitor: write pulses and illegal rd=0 without wr
    int wr_pulses = 0;
    int bad_port  = 0;
    always @(negedge clk) begin
        if (ram_wr === 1'b1) wr_pulses <= wr_pulses + 1;
        if (ram_wr !== 1'b1 && ram_rd !== 1'b1) bad_port <= bad_port + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] ref_mem [256];
    logic [7:0] ref_sp;
    logic [7:0] ref_rdata;
    logic       ref_rbit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram_mem[i] !== ref_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    // One request: model first, then drive and compare
    task automatic do_op(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wd,
                         input logic [1:0] rs, input bit pre_spwr, input logic [7:0] spval,
                         input bit busy_spwr, input string tag);
        int   exp_lat;
        bit   exp_err;
        bit   is_rd;
        int   k;
        int   bidx;
        logic [7:0] ptr;
        @(negedge clk);
        chk({tag, "_ack_idle"}, 32'(exu.ack), 32'd0);
        exu.op = op; exu.addr = addr; exu.wdata = wd; exu.rs = rs;
        if (pre_spwr) begin
            exu.sp_wr = 1'b1; exu.sp_wdata = spval; exu.req = 1'b1;
            @(negedge clk);
            exu.sp_wr = 1'b0;
            ref_sp = spval;
            chk({tag, "_spwr_noacc"}, 32'(exu.busy), 32'd0);
            chk({tag, "_spwr_sp"}, 32'(exu.sp), 32'(ref_sp));
        end
        exp_err = 1'b0;
        exp_lat = 0;
        is_rd = (op == OP_RD) || (op == OP_IRD) || (op == OP_POP) || (op == OP_BRD);
        case (op)
            OP_RD, OP_WR: begin
                if (addr >= 8'h80) exp_err = 1'b1;
                else if (op == OP_RD) begin ref_rdata = ref_mem[addr]; exp_lat = 3; end
                else begin ref_mem[addr] = wd; exp_lat = 2; end
            end
            OP_IRD, OP_IWR: begin
                ptr = ref_mem[8 * rs + (addr % 2)];
                if (ptr >= 8'h80) begin exp_err = 1'b1; exp_lat = 3; end
                else if (op == OP_IRD) begin ref_rdata = ref_mem[ptr]; exp_lat = 5; end
                else begin ref_mem[ptr] = wd; exp_lat = 4; end
            end
            OP_PUSH: begin
                ref_sp = ref_sp + 8'd1;
                if (ref_sp >= 8'h80) exp_err = 1'b1;
                else begin ref_mem[ref_sp] = wd; exp_lat = 2; end
            end
            OP_POP: begin
                if (ref_sp >= 8'h80) exp_err = 1'b1;
                else begin ref_rdata = ref_mem[ref_sp]; ref_sp = ref_sp - 8'd1; exp_lat = 3; end
            end
            default: begin
                bidx = 32 + addr / 8;
                if (addr >= 8'h80) exp_err = 1'b1;
                else if (op == OP_BRD) begin ref_rbit = ref_mem[bidx][addr % 8]; exp_lat = 3; end
                else begin ref_mem[bidx][addr % 8] = wd[0]; exp_lat = 2; end
            end
        endcase
        if (exp_err && exp_lat == 0) exp_lat = 1;
        if (exp_err && is_rd) begin ref_rdata = 8'hFF; ref_rbit = 1'b0; end

        exu.req = 1'b1;
        @(posedge clk);
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (exu.ack === 1'b1) break;
            exu.sp_wr = busy_spwr && (k == 1);
            exu.sp_wdata = 8'($urandom);
        end
        exu.sp_wr = 1'b0;
        exu.req = 1'b0;
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "_busy_at_ack"}, 32'(exu.busy), 32'd1);
        chk({tag, "_err"}, 32'(exu.err), 32'(exp_err));
        if (is_rd && (exp_err || op != OP_BRD)) chk({tag, "_rdata"}, 32'(exu.rdata), 32'(ref_rdata));
        if (is_rd && (exp_err || op == OP_BRD)) chk({tag, "_rbit"}, 32'(exu.rbit), 32'(ref_rbit));
        chk({tag, "_sp"}, 32'(exu.sp), 32'(ref_sp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp;
        logic [2:0] rop;
        logic [7:0] raddr, rsp;
        exu.req = 1'b0; exu.op = 3'd0; exu.addr = 8'h00; exu.wdata = 8'h00;
        exu.rs = 2'd0; exu.sp_wr = 1'b0; exu.sp_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(exu.busy), 32'd0);
        chk("rst_ack", 32'(exu.ack), 32'd0);
        chk("rst_err", 32'(exu.err), 32'd0);
        chk("rst_rbit", 32'(exu.rbit), 32'd0);
        chk("rst_rdata", 32'(exu.rdata), 32'd0);
        chk("rst_sp", 32'(exu.sp), 32'h07);
        chk("rst_ram_rd", 32'(ram_rd), 32'd1);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_bit", 32'(ram_is_bit), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];
        ref_sp = 8'h07; ref_rdata = 8'h00; ref_rbit = 1'b0;
        rst = 1'b1;

        // Direct write / read
        do_op(OP_WR, 8'h30, 8'h5A, 2'd0, 0, 8'h00, 0, "wr30");
        do_op(OP_RD, 8'h30, 8'h00, 2'd0, 0, 8'h00, 0, "rd30");
        chk("rd30_const", 32'(exu.rdata), 32'h5A);

        // Indirect read through R1 of bank 1
        do_op(OP_WR, 8'h09, 8'h40, 2'd1, 0, 8'h00, 0, "wr09");
        do_op(OP_WR, 8'h40, 8'hC3, 2'd1, 0, 8'h00, 0, "wr40");
        do_op(OP_IRD, 8'h01, 8'h00, 2'd1, 0, 8'h00, 0, "ird");
        chk("ird_const", 32'(exu.rdata), 32'hC3);

        // Stack
        do_op(OP_PUSH, 8'h00, 8'h11, 2'd0, 0, 8'h00, 0, "push1");
        do_op(OP_PUSH, 8'h00, 8'h22, 2'd0, 0, 8'h00, 1, "push2");
        chk("push_mem08", 32'(ram_mem[8'h08]), 32'h11);
        chk("push_mem09", 32'(ram_mem[8'h09]), 32'h22);
        chk("push_sp", 32'(exu.sp), 32'h09);
        do_op(OP_POP, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, "pop1");
        chk("pop1_const", 32'(exu.rdata), 32'h22);
        do_op(OP_POP, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, "pop2");
        chk("pop2_const", 32'(exu.rdata), 32'h11);
        chk("pop_sp", 32'(exu.sp), 32'h07);

        // SFR region refusals
        wp = wr_pulses;
        do_op(OP_PUSH, 8'h00, 8'h33, 2'd0, 1, 8'h7F, 0, "push_sfr");
        chk("push_sfr_sp", 32'(exu.sp), 32'h80);
        chk("push_sfr_nowr", 32'(wr_pulses), 32'(wp));
        do_op(OP_WR, 8'h08, 8'h90, 2'd0, 0, 8'h00, 0, "wr08");
        do_op(OP_IRD, 8'h00, 8'h00, 2'd1, 0, 8'h00, 0, "ird_sfr");
        chk("ird_sfr_rdata", 32'(exu.rdata), 32'hFF);

        // Bit access
        do_op(OP_WR, 8'h21, 8'h00, 2'd0, 0, 8'h00, 0, "wr21");
        do_op(OP_BWR, 8'h0B, 8'h01, 2'd0, 0, 8'h00, 0, "bwr0b");
        do_op(OP_BRD, 8'h0B, 8'h00, 2'd0, 0, 8'h00, 0, "brd0b");
        chk("brd0b_const", 32'(exu.rbit), 32'd1);
        chk("bwr_mem21", 32'(ram_mem[8'h21]), 32'h08);
        do_op(OP_BRD, 8'h85, 8'h00, 2'd0, 0, 8'h00, 0, "brd_sfr");
        chk_mem("mem_directed");

        // Reset in the middle of an indirect write
        do_op(OP_RD, 8'h30, 8'h00, 2'd0, 1, 8'h30, 0, "rd_spset");
        do_op(OP_WR, 8'h10, 8'h50, 2'd2, 0, 8'h00, 0, "wr10");
        @(negedge clk);
        wp = wr_pulses;
        exu.op = OP_IWR; exu.addr = 8'h00; exu.wdata = 8'hEE; exu.rs = 2'd2; exu.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exu.req = 1'b0;
        #1;
        chk("midrst_busy", 32'(exu.busy), 32'd0);
        chk("midrst_ack", 32'(exu.ack), 32'd0);
        chk("midrst_ram_wr", 32'(ram_wr), 32'd0);
        chk("midrst_ram_rd", 32'(ram_rd), 32'd1);
        chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
        chk("midrst_sp", 32'(exu.sp), 32'h07);
        chk("midrst_rdata", 32'(exu.rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ref_sp = 8'h07; ref_rdata = 8'h00; ref_rbit = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_nowr", 32'(wr_pulses), 32'(wp));
        chk_mem("mem_after_rst");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rop = 3'($urandom_range(0, 7));
            raddr = (rop == OP_RD || rop == OP_WR) ? 8'($urandom_range(0, 127)) : 8'($urandom);
            case ($urandom_range(0, 4))
                0: rsp = 8'h00;
                1: rsp = 8'hFF;
                2: rsp = 8'h7F;
                3: rsp = 8'h80;
                default: rsp = 8'($urandom);
            endcase
            do_op(rop, raddr, 8'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0), rsp,
                  ($urandom_range(0, 3) == 0), "rand");
        end
        chk_mem("mem_random");
        chk("port_rd_only_on_write", 32'(bad_port), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
